game_snapshot_tx_sched: RTL and testbench

Frame scheduler between the game-state snapshot and the UART transmitter of the UART_Memoria design. On a start request or a periodic tick it latches one coherent snapshot of game state: FSM state, difficulty, 81-cell board, cell colors, cursor, errors, selected number, victory, score and time. It then streams the snapshot as a fixed 70-byte frame with header and XOR checksum over a valid/ready byte handshake to the UART TX. It also arbitrates between manual and periodic requests, so that at most one frame is in flight.

---
 rtl/game_snapshot_tx_sched_if.sv | 9 +
 rtl/game_snapshot_tx_sched.sv | 127 ++++++++++++
 tb/tb_game_snapshot_tx_sched.sv | 259 +++++++++++++++++++++++++
 3 files changed

// File: rtl/game_snapshot_tx_sched_if.sv
// Byte-stream handshake between the snapshot scheduler and the UART transmitter.
interface game_snapshot_tx_sched_if;
  logic [7:0] tx_data;
  logic       tx_valid;
  logic       tx_ready;

  modport master (output tx_data, output tx_valid, input tx_ready);
  modport slave  (input tx_data, input tx_valid, output tx_ready);
endinterface

// File: rtl/game_snapshot_tx_sched.sv
// Latches one coherent game-state snapshot on a start or periodic tick and streams
// it as a 70-byte frame (header, 68 payload bytes, XOR checksum) to the UART TX.
module game_snapshot_tx_sched #(
  parameter logic [7:0] HEADER      = 8'hA5,
  parameter int         AUTO_PERIOD = 0
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start,
  input  logic [2:0]   current_state,
  input  logic         game_dificulty,
  input  logic [323:0] full_board,
  input  logic [161:0] colors,
  input  logic [7:0]   position,
  input  logic [1:0]   errors,
  input  logic [3:0]   selected_number,
  input  logic         victory_condition,
  input  logic [6:0]   score,
  input  logic [10:0]  time_in_seconds,
  game_snapshot_tx_sched_if.master tx,
  output logic         busy,
  output logic         frame_done
);

  localparam int             CW   = (AUTO_PERIOD > 1) ? $clog2(AUTO_PERIOD) : 1;
  localparam logic [CW-1:0]  LAST = CW'(AUTO_PERIOD - 1);
  localparam logic [6:0]     LAST_IDX = 7'd69;

  typedef enum logic [1:0] {IDLE, SEND, DONE} state_t;

  state_t        state_q, state_d;
  logic [551:0]  frame_q, frame_d;
  logic [6:0]    idx_q, idx_d;
  logic [7:0]    csum_q, csum_d;
  logic          pend_q, pend_d;
  logic [CW-1:0] cnt_q, cnt_d;

  logic          tick;
  logic          req;
  logic [551:0]  snapshot;

  assign snapshot = {HEADER,
                     current_state, game_dificulty, errors, victory_condition, 1'b0,
                     position,
                     4'b0, selected_number,
                     1'b0, score,
                     5'b0, time_in_seconds[10:8],
                     time_in_seconds[7:0],
                     4'b0, full_board,
                     6'b0, colors};

  always_comb begin
    tick  = (AUTO_PERIOD != 0) && (cnt_q == LAST);
    cnt_d = ((AUTO_PERIOD == 0) || tick) ? '0 : cnt_q + CW'(1);
    req   = start | tick;

    state_d     = state_q;
    frame_d     = frame_q;
    idx_d       = idx_q;
    csum_d      = csum_q;
    pend_d      = pend_q;
    tx.tx_valid = 1'b0;
    tx.tx_data  = 8'h00;
    busy        = 1'b0;
    frame_done  = 1'b0;

    case (state_q)
      IDLE: begin
        if (req) begin
          frame_d = snapshot;
          idx_d   = '0;
          csum_d  = '0;
          pend_d  = 1'b0;
          state_d = SEND;
        end
      end
      SEND: begin
        busy        = 1'b1;
        tx.tx_valid = 1'b1;
        tx.tx_data  = (idx_q == LAST_IDX) ? csum_q : frame_q[551:544];
        if (req) pend_d = 1'b1;
        if (tx.tx_ready) begin
          if (idx_q == LAST_IDX) begin
            state_d = DONE;
          end else begin
            // header byte is excluded from the checksum
            if (idx_q != 7'd0) csum_d = csum_q ^ frame_q[551:544];
            frame_d = {frame_q[543:0], 8'h00};
            idx_d   = idx_q + 7'd1;
          end
        end
      end
      DONE: begin
        frame_done = 1'b1;
        if (req || pend_q) begin
          frame_d = snapshot;
          idx_d   = '0;
          csum_d  = '0;
          pend_d  = 1'b0;
          state_d = SEND;
        end else begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      frame_q <= '0;
      idx_q   <= '0;
      csum_q  <= '0;
      pend_q  <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      frame_q <= frame_d;
      idx_q   <= idx_d;
      csum_q  <= csum_d;
      pend_q  <= pend_d;
      cnt_q   <= cnt_d;
    end
  end

endmodule

// File: tb/tb_game_snapshot_tx_sched.sv
// Directed bench for the snapshot frame scheduler: snapshot vector table, stalls,
// mid-frame input changes, request collapsing, periodic trigger and mid-frame reset.
module tb_game_snapshot_tx_sched;

  logic         clk = 1'b0;
  logic         rst_n, rst2_n, start, start2;
  logic [2:0]   current_state;
  logic         game_dificulty;
  logic [323:0] full_board;
  logic [161:0] colors;
  logic [7:0]   position;
  logic [1:0]   errors;
  logic [3:0]   selected_number;
  logic         victory_condition;
  logic [6:0]   score;
  logic [10:0]  time_in_seconds;
  logic         busy, frame_done, busy2, done2;

  int total = 0;
  int bad   = 0;
  logic [7:0] got [70];
  int n_hs;

  always #5 clk = ~clk;

  game_snapshot_tx_sched_if bus1 ();
  game_snapshot_tx_sched_if bus2 ();

  game_snapshot_tx_sched #(.HEADER(8'hA5), .AUTO_PERIOD(0)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .current_state(current_state),
    .game_dificulty(game_dificulty), .full_board(full_board), .colors(colors),
    .position(position), .errors(errors), .selected_number(selected_number),
    .victory_condition(victory_condition), .score(score), .time_in_seconds(time_in_seconds),
    .tx(bus1.master), .busy(busy), .frame_done(frame_done));

  game_snapshot_tx_sched #(.HEADER(8'hA5), .AUTO_PERIOD(200)) dut_auto (
    .clk(clk), .rst_n(rst2_n), .start(start2), .current_state(current_state),
    .game_dificulty(game_dificulty), .full_board(full_board), .colors(colors),
    .position(position), .errors(errors), .selected_number(selected_number),
    .victory_condition(victory_condition), .score(score), .time_in_seconds(time_in_seconds),
    .tx(bus2.master), .busy(busy2), .frame_done(done2));

  typedef struct {
    logic [2:0]   cs;
    logic         dif;
    logic [1:0]   err;
    logic         vic;
    logic [7:0]   pos;
    logic [3:0]   sel;
    logic [6:0]   sc;
    logic [10:0]  tm;
    logic [323:0] board;
    logic [161:0] col;
    logic [7:0]   eb [1:7];
  } vec_t;

  localparam logic [323:0] BOARD_A = {24'h019638, {25{12'h5A3}}};
  localparam logic [161:0] COL_A   = {10'b0010101011, {19{8'b1100_0110}}};

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic apply(input vec_t v);
    current_state = v.cs; game_dificulty = v.dif; errors = v.err; victory_condition = v.vic;
    position = v.pos; selected_number = v.sel; score = v.sc; time_in_seconds = v.tm;
    full_board = v.board; colors = v.col;
  endtask

  function automatic logic [7:0] exp_byte(input vec_t v, input int k);
    logic [551:0] f;
    logic [7:0]   x;
    f = {8'hA5, v.cs, v.dif, v.err, v.vic, 1'b0, v.pos, 4'b0, v.sel, 1'b0, v.sc,
         5'b0, v.tm[10:8], v.tm[7:0], 4'b0, v.board, 6'b0, v.col};
    if (k < 69) return f[551 - 8*k -: 8];
    x = 8'h00;
    for (int j = 1; j < 69; j++) x = x ^ f[551 - 8*j -: 8];
    return x;
  endfunction

  // Request a frame and check that the header appears one cycle after the sampling edge.
  task automatic pulse_start();
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    check("latency_valid", {31'b0, bus1.tx_valid}, 32'd1);
    check("latency_hdr", {24'b0, bus1.tx_data}, 32'hA5);
    check("latency_busy", {31'b0, busy}, 32'd1);
  endtask

  task automatic run_frame(input bit rnd, input int change_at, input bit pulses, input int rst_at);
    int   hs, cyc;
    bit   prev_stall, fin;
    logic [7:0] prev_data;
    hs = 0; cyc = 0; prev_stall = 0; fin = 0; prev_data = 8'h00;
    while (!fin && cyc < 3000) begin
      @(negedge clk); cyc++;
      start = 1'b0;
      if (prev_stall) begin
        check("stall_valid", {31'b0, bus1.tx_valid}, 32'd1);
        check("stall_data", {24'b0, bus1.tx_data}, {24'b0, prev_data});
      end
      if (frame_done) begin
        fin = 1; bus1.tx_ready = 1'b0;
      end else begin
        bus1.tx_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
        if (bus1.tx_valid && bus1.tx_ready) begin
          if (hs < 70) got[hs] = bus1.tx_data;
          hs++;
          if (hs == change_at) score = 7'd5;
          if (pulses && (hs == 10 || hs == 20 || hs == 25)) start = 1'b1;
          if (hs == rst_at) begin
            rst_n = 1'b0; start = 1'b0; bus1.tx_ready = 1'b0; fin = 1;
          end
        end
        prev_stall = bus1.tx_valid && !bus1.tx_ready;
        prev_data  = bus1.tx_data;
      end
    end
    if (!fin) check("frame_timeout", 32'd0, 32'd1);
    n_hs = hs;
  endtask

  task automatic check_frame(input vec_t v);
    check("handshakes", n_hs, 32'd70);
    for (int k = 0; k < 70; k++)
      check($sformatf("byte%0d", k), {24'b0, got[k]}, {24'b0, exp_byte(v, k)});
  endtask

  vec_t vt [4];
  vec_t v5;

  initial begin
    int ones, i, prev_v, idx;
    int rises [3];
    bit seen;

    vt[0] = '{cs:3'b101, dif:1'b1, err:2'd2, vic:1'b1, pos:8'h58, sel:4'd3, sc:7'd100, tm:11'd0,
              board:BOARD_A, col:COL_A, eb:'{8'hBA, 8'h58, 8'h03, 8'h64, 8'h00, 8'h00, 8'h00}};
    vt[1] = '{cs:3'b000, dif:1'b0, err:2'd0, vic:1'b0, pos:8'h00, sel:4'd0, sc:7'd0, tm:11'd0,
              board:'0, col:'0, eb:'{8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00}};
    vt[2] = '{cs:3'b111, dif:1'b1, err:2'd3, vic:1'b1, pos:8'hFF, sel:4'hF, sc:7'd127, tm:11'd2047,
              board:'1, col:'1, eb:'{8'hFE, 8'hFF, 8'h0F, 8'h7F, 8'h07, 8'hFF, 8'h0F}};
    vt[3] = '{cs:3'b010, dif:1'b0, err:2'd1, vic:1'b0, pos:8'h3A, sel:4'd9, sc:7'd5, tm:11'h123,
              board:BOARD_A, col:COL_A, eb:'{8'h44, 8'h3A, 8'h09, 8'h05, 8'h01, 8'h23, 8'h00}};

    rst_n = 1'b0; rst2_n = 1'b0; start = 1'b0; start2 = 1'b0;
    bus1.tx_ready = 1'b0; bus2.tx_ready = 1'b0;
    apply(vt[0]);
    repeat (3) @(negedge clk);
    check("rst_valid", {31'b0, bus1.tx_valid}, 32'd0);
    check("rst_data", {24'b0, bus1.tx_data}, 32'd0);
    check("rst_busy", {31'b0, busy}, 32'd0);
    check("rst_done", {31'b0, frame_done}, 32'd0);
    rst_n = 1'b1;

    // Snapshot vector table, tx_ready held high
    for (int t = 0; t < 4; t++) begin
      apply(vt[t]);
      pulse_start();
      run_frame(0, -1, 0, -1);
      for (int b = 1; b < 8; b++)
        check($sformatf("vec%0d_b%0d", t, b), {24'b0, got[b]}, {24'b0, vt[t].eb[b]});
      check_frame(vt[t]);
      @(negedge clk);
      check("done_once", {31'b0, frame_done}, 32'd0);
    end
    apply(vt[0]);
    pulse_start();
    run_frame(0, -1, 0, -1);
    check("b8", {24'b0, got[8]}, 32'h19);
    check("b9", {24'b0, got[9]}, 32'h63);
    check("b48", {24'b0, got[48]}, 32'h00);
    check("b49", {24'b0, got[49]}, 32'hAB);

    // Random stalls
    @(negedge clk);
    pulse_start();
    run_frame(1, -1, 0, -1);
    check_frame(vt[0]);

    // Score changes mid-frame; next frame picks it up
    @(negedge clk);
    pulse_start();
    run_frame(0, 10, 0, -1);
    check("midchg_b4", {24'b0, got[4]}, 32'h64);
    check_frame(vt[0]);
    @(negedge clk);
    pulse_start();
    run_frame(0, -1, 0, -1);
    check("next_b4", {24'b0, got[4]}, 32'h05);
    v5 = vt[0]; v5.sc = 7'd5;
    check_frame(v5);
    apply(vt[0]);

    // Three requests during SEND collapse into one back-to-back frame
    @(negedge clk);
    pulse_start();
    run_frame(0, -1, 1, -1);
    check("pend_first_hs", n_hs, 32'd70);
    @(negedge clk);
    check("pend_gap_valid", {31'b0, bus1.tx_valid}, 32'd1);
    check("pend_gap_hdr", {24'b0, bus1.tx_data}, 32'hA5);
    check("pend_gap_done", {31'b0, frame_done}, 32'd0);
    run_frame(0, -1, 0, -1);
    check_frame(vt[0]);
    ones = 0;
    repeat (100) begin @(negedge clk); if (bus1.tx_valid) ones++; end
    check("no_extra_frame", ones, 32'd0);

    // Reset at byte 30 with a request pending
    pulse_start();
    run_frame(0, -1, 1, 30);
    @(negedge clk);
    check("rstmid_valid", {31'b0, bus1.tx_valid}, 32'd0);
    check("rstmid_busy", {31'b0, busy}, 32'd0);
    check("rstmid_done", {31'b0, frame_done}, 32'd0);
    rst_n = 1'b1;
    ones = 0;
    repeat (100) begin @(negedge clk); if (bus1.tx_valid) ones++; end
    check("pend_lost", ones, 32'd0);
    pulse_start();
    run_frame(0, -1, 0, -1);
    check_frame(vt[0]);

    // Periodic trigger, period 200
    bus2.tx_ready = 1'b1;
    rst2_n = 1'b1;
    i = 0; prev_v = 0; idx = 0;
    rises[0] = 0; rises[1] = 0; rises[2] = 0;
    while (idx < 3 && i < 1000) begin
      @(negedge clk); i++;
      if (bus2.tx_valid && prev_v == 0) begin rises[idx] = i; idx++; end
      prev_v = bus2.tx_valid ? 1 : 0;
    end
    check("auto_rise0", rises[0], 32'd200);
    check("auto_rise1", rises[1], 32'd400);
    check("auto_rise2", rises[2], 32'd600);
    check("auto_hdr", {24'b0, bus2.tx_data}, 32'hA5);
    bus2.tx_ready = 1'b0;
    repeat (450) @(negedge clk);
    check("auto_stall_busy", {31'b0, busy2}, 32'd1);
    check("auto_stall_hdr", {24'b0, bus2.tx_data}, 32'hA5);
    bus2.tx_ready = 1'b1;
    seen = 0; i = 0;
    while (!seen && i < 200) begin @(negedge clk); i++; if (done2) seen = 1; end
    check("auto_done_seen", {31'b0, seen}, 32'd1);
    @(negedge clk);
    check("auto_pend_valid", {31'b0, bus2.tx_valid}, 32'd1);
    check("auto_pend_hdr", {24'b0, bus2.tx_data}, 32'hA5);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
